// File: rtl/rtc_set_ctrl_if.sv
// Button, time-readback and load/advance signals between the RTC set controller
// and the BCD counter chain; master is the controller side.
interface rtc_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] cur_hr;
  logic [7:0] cur_min;
  logic [7:0] cur_sec;
  logic       cnt_en;
  logic       ld_en;
  logic [7:0] ld_hr;
  logic [7:0] ld_min;
  logic [7:0] ld_sec;
  logic [2:0] mode;
  logic       alarm;

  modport master (
    input  btn_mode, btn_inc, cur_hr, cur_min, cur_sec,
    output cnt_en, ld_en, ld_hr, ld_min, ld_sec, mode, alarm
  );

  modport slave (
    output btn_mode, btn_inc, cur_hr, cur_min, cur_sec,
    input  cnt_en, ld_en, ld_hr, ld_min, ld_sec, mode, alarm
  );
endinterface

// File: rtl/rtc_set_ctrl.sv
// RTC time-set controller: one-second prescaler, BCD field editing and load strobe.
// Optional alarm registers and alarm flag are built when RTC_ALARM_EN is defined.
//
// state     | meaning
// RUN       | time advancing, prescaler counting
// SET_HR    | editing shadow hours
// SET_MIN   | editing shadow minutes
// SET_SEC   | editing shadow seconds
// LOAD      | one-cycle load strobe of shadows into the counter chain
// ALM_HR    | editing alarm hours   (RTC_ALARM_EN only)
// ALM_MIN   | editing alarm minutes (RTC_ALARM_EN only)
module rtc_set_ctrl #(
  parameter int unsigned TICK_DIV = 100
) (
  input logic           clkin,
  input logic           rst,
  rtc_set_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SET_HR  = 3'd1,
    S_SET_MIN = 3'd2,
    S_SET_SEC = 3'd3,
    S_LOAD    = 3'd4
`ifdef RTC_ALARM_EN
    ,
    S_ALM_HR  = 3'd5,
    S_ALM_MIN = 3'd6
`endif
  } state_t;

  localparam logic [15:0] C_TC = 16'(TICK_DIV - 1);

  state_t      r_state;
  logic [15:0] r_presc;
  logic        r_cnt_en;
  logic        r_ld_en;
  logic [7:0]  r_ld_hr;
  logic [7:0]  r_ld_min;
  logic [7:0]  r_ld_sec;
  logic [7:0]  r_sh_hr;
  logic [7:0]  r_sh_min;
  logic [7:0]  r_sh_sec;
  logic        w_mode;
  logic        w_inc;
  logic [15:0] w_presc_nxt;

  // Out-of-range values also wrap to 00 so a corrupt readback cannot run away.
  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] res;
    if (v >= vmax) res = 8'h00;
    else if (v[3:0] == 4'd9) res = {v[7:4] + 4'd1, 4'd0};
    else res = {v[7:4], v[3:0] + 4'd1};
    return res;
  endfunction

`ifdef RTC_ALARM_EN
  logic       r_alarm;
  logic [7:0] r_alm_hr;
  logic [7:0] r_alm_min;
  logic       w_alm_match;

  // A pending alarm swallows every button pulse until it is acknowledged.
  assign w_mode      = bus.btn_mode && !r_alarm;
  assign w_inc       = bus.btn_inc && !bus.btn_mode && !r_alarm;
  assign w_alm_match = (bus.cur_hr == r_alm_hr) && (bus.cur_min == r_alm_min)
                       && (bus.cur_sec == 8'h00);
  assign bus.alarm   = r_alarm;
`else
  assign w_mode      = bus.btn_mode;
  assign w_inc       = bus.btn_inc && !bus.btn_mode;
  assign bus.alarm   = 1'b0;
`endif

  assign w_presc_nxt = (r_presc == C_TC) ? 16'd0 : r_presc + 16'd1;

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_presc   <= '0;
      r_cnt_en  <= 1'b0;
      r_ld_en   <= 1'b0;
      r_ld_hr   <= '0;
      r_ld_min  <= '0;
      r_ld_sec  <= '0;
      r_sh_hr   <= '0;
      r_sh_min  <= '0;
      r_sh_sec  <= '0;
`ifdef RTC_ALARM_EN
      r_alarm   <= 1'b0;
      r_alm_hr  <= '0;
      r_alm_min <= '0;
`endif
    end else begin
      r_presc  <= '0;
      r_cnt_en <= 1'b0;
      r_ld_en  <= 1'b0;
      r_ld_hr  <= '0;
      r_ld_min <= '0;
      r_ld_sec <= '0;
`ifdef RTC_ALARM_EN
      if (r_alarm && (bus.btn_mode || bus.btn_inc)) r_alarm <= 1'b0;
      else if (r_cnt_en && w_alm_match) r_alarm <= 1'b1;
`endif
      case (r_state)
        S_RUN: begin
          if (w_mode) begin
            r_state  <= S_SET_HR;
            r_sh_hr  <= bus.cur_hr;
            r_sh_min <= bus.cur_min;
            r_sh_sec <= bus.cur_sec;
          end else begin
            r_presc  <= w_presc_nxt;
            r_cnt_en <= (w_presc_nxt == C_TC);
          end
        end
        S_SET_HR: begin
          if (w_mode) r_state <= S_SET_MIN;
          else if (w_inc) r_sh_hr <= f_bcd_inc(r_sh_hr, 8'h23);
        end
        S_SET_MIN: begin
          if (w_mode) r_state <= S_SET_SEC;
          else if (w_inc) r_sh_min <= f_bcd_inc(r_sh_min, 8'h59);
        end
        S_SET_SEC: begin
          if (w_mode) begin
`ifdef RTC_ALARM_EN
            r_state  <= S_ALM_HR;
`else
            r_state  <= S_LOAD;
            r_ld_en  <= 1'b1;
            r_ld_hr  <= r_sh_hr;
            r_ld_min <= r_sh_min;
            r_ld_sec <= r_sh_sec;
`endif
          end else if (w_inc) r_sh_sec <= f_bcd_inc(r_sh_sec, 8'h59);
        end
`ifdef RTC_ALARM_EN
        S_ALM_HR: begin
          if (w_mode) r_state <= S_ALM_MIN;
          else if (w_inc) r_alm_hr <= f_bcd_inc(r_alm_hr, 8'h23);
        end
        S_ALM_MIN: begin
          if (w_mode) begin
            r_state  <= S_LOAD;
            r_ld_en  <= 1'b1;
            r_ld_hr  <= r_sh_hr;
            r_ld_min <= r_sh_min;
            r_ld_sec <= r_sh_sec;
          end else if (w_inc) r_alm_min <= f_bcd_inc(r_alm_min, 8'h59);
        end
`endif
        S_LOAD:  r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign bus.cnt_en = r_cnt_en;
  assign bus.ld_en  = r_ld_en;
  assign bus.ld_hr  = r_ld_hr;
  assign bus.ld_min = r_ld_min;
  assign bus.ld_sec = r_ld_sec;
  assign bus.mode   = r_state;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Self-checking bench for rtc_set_ctrl: directed scenarios followed by random button
// traffic, all compared against a decimal-arithmetic reference model.
module tb_rtc_set_ctrl;

  localparam int TD = 4;
`ifdef RTC_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic clkin = 1'b0;
  logic rst   = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: time fields held as plain decimal integers.
  int ch, cm, cs;
  int m_st, m_cnt;
  int sh_h, sh_m, sh_s, al_h, al_m;
  bit m_alarm;

  rtc_set_ctrl_if bus ();

  rtc_set_ctrl #(.TICK_DIV(TD)) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    ch = h; cm = m; cs = s;
    bus.cur_hr  = bcd(h);
    bus.cur_min = bcd(m);
    bus.cur_sec = bcd(s);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0;
    sh_h = 0; sh_m = 0; sh_s = 0; al_h = 0; al_m = 0;
    m_alarm = 1'b0;
  endtask

  task automatic check_model();
    bit ld;
    ld = (m_st == 4);
    chk("mode",   32'(bus.mode),   32'(m_st));
    chk("cnt_en", 32'(bus.cnt_en), 32'((m_st == 0) && (m_cnt == TD - 1)));
    chk("ld_en",  32'(bus.ld_en),  32'(ld));
    chk("ld_hr",  32'(bus.ld_hr),  32'(ld ? bcd(sh_h) : 8'h00));
    chk("ld_min", 32'(bus.ld_min), 32'(ld ? bcd(sh_m) : 8'h00));
    chk("ld_sec", 32'(bus.ld_sec), 32'(ld ? bcd(sh_s) : 8'h00));
    chk("alarm",  32'(bus.alarm),  32'(m_alarm));
  endtask

  task automatic model_step(input bit r, input bit bm, input bit bi);
    bit tick, consumed;
    int nxt;
    if (r) begin
      model_reset();
      return;
    end
    tick     = (m_st == 0) && (m_cnt == TD - 1);
    consumed = ALM && m_alarm && (bm || bi);
    if (consumed) m_alarm = 1'b0;
    else if (ALM && tick && ch == al_h && cm == al_m && cs == 0) m_alarm = 1'b1;
    nxt = m_st;
    if (m_st == 4) nxt = 0;
    else if (!consumed) begin
      if (m_st == 0) begin
        if (bm) begin
          nxt = 1; sh_h = ch; sh_m = cm; sh_s = cs;
        end
      end else if (bm) begin
        if (m_st == 3) nxt = ALM ? 5 : 4;
        else if (m_st == 6) nxt = 4;
        else nxt = m_st + 1;
      end else if (bi) begin
        case (m_st)
          1: sh_h = (sh_h + 1) % 24;
          2: sh_m = (sh_m + 1) % 60;
          3: sh_s = (sh_s + 1) % 60;
          5: al_h = (al_h + 1) % 24;
          6: al_m = (al_m + 1) % 60;
          default: ;
        endcase
      end
    end
    m_cnt = (m_st == 0 && nxt == 0) ? (m_cnt + 1) % TD : 0;
    m_st  = nxt;
  endtask

  task automatic cyc(input bit r, input bit bm, input bit bi);
    check_model();
    rst = r;
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    model_step(r, bm, bi);
    @(posedge clkin);
    #1;
    rst = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic to_load_from_sec();
    cyc(0, 1, 0);
    if (ALM) begin
      cyc(0, 1, 0);
      cyc(0, 1, 0);
    end
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    set_cur(0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_mode",   32'(bus.mode),   32'd0);
    chk("rst_cnt_en", 32'(bus.cnt_en), 32'd0);
    chk("rst_ld_en",  32'(bus.ld_en),  32'd0);
    chk("rst_ld_hr",  32'(bus.ld_hr),  32'h00);
    chk("rst_alarm",  32'(bus.alarm),  32'd0);

    // Prescaler ticks on RUN cycles 3, 7 and 11 only.
    for (int i = 0; i < 12; i++) begin
      chk("tick_pattern", 32'(bus.cnt_en), 32'((i % 4) == 3));
      cyc(0, 0, 0);
    end

    // Edit 12:34:56 to 15:34:56 and load it.
    set_cur(12, 34, 56);
    cyc(0, 1, 0);
    chk("set_hr_state", 32'(bus.mode), 32'd1);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    to_load_from_sec();
    chk("load_en",  32'(bus.ld_en),  32'd1);
    chk("load_hr",  32'(bus.ld_hr),  32'h15);
    chk("load_min", 32'(bus.ld_min), 32'h34);
    chk("load_sec", 32'(bus.ld_sec), 32'h56);
    cyc(0, 1, 1);
    chk("post_load_mode",  32'(bus.mode),  32'd0);
    chk("post_load_ld_en", 32'(bus.ld_en), 32'd0);
    chk("post_load_ld_hr", 32'(bus.ld_hr), 32'h00);
    for (int i = 0; i < 4; i++) begin
      chk("first_tick_after_load", 32'(bus.cnt_en), 32'(i == 3));
      cyc(0, 0, 0);
    end

    // Field wraps: 23->00, 59->00, 09->10.
    set_cur(23, 59, 9);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    to_load_from_sec();
    chk("wrap_hr",  32'(bus.ld_hr),  32'h00);
    chk("wrap_min", 32'(bus.ld_min), 32'h00);
    chk("wrap_sec", 32'(bus.ld_sec), 32'h10);
    cyc(0, 0, 0);

    // Simultaneous buttons: mode wins, minute untouched.
    set_cur(8, 45, 17);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    chk("both_btn_state", 32'(bus.mode), 32'd3);
    to_load_from_sec();
    chk("both_btn_min", 32'(bus.ld_min), 32'h45);
    cyc(0, 0, 0);

    // Reset mid-edit, with a mode pulse that must be overridden.
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("pre_rst_state", 32'(bus.mode), 32'd3);
    cyc(1, 1, 0);
    chk("rst_edit_mode",  32'(bus.mode),  32'd0);
    chk("rst_edit_ld_en", 32'(bus.ld_en), 32'd0);
    repeat (3) cyc(0, 0, 0);

`ifdef RTC_ALARM_EN
    // Alarm at 07:30, fired by a tick at 07:30:00, acknowledged by a mode pulse.
    set_cur(1, 2, 3);
    repeat (4) cyc(0, 1, 0);
    chk("alm_hr_state", 32'(bus.mode), 32'd5);
    repeat (7) cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("alm_min_state", 32'(bus.mode), 32'd6);
    repeat (30) cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("alm_load_state", 32'(bus.mode), 32'd4);
    set_cur(7, 30, 0);
    cyc(0, 0, 0);
    repeat (3) cyc(0, 0, 0);
    chk("alm_tick", 32'(bus.cnt_en), 32'd1);
    chk("alm_before", 32'(bus.alarm), 32'd0);
    cyc(0, 0, 0);
    chk("alm_set", 32'(bus.alarm), 32'd1);
    set_cur(7, 30, 1);
    cyc(0, 0, 0);
    chk("alm_hold", 32'(bus.alarm), 32'd1);
    cyc(0, 1, 0);
    chk("alm_clear", 32'(bus.alarm), 32'd0);
    chk("alm_clear_mode", 32'(bus.mode), 32'd0);
`endif

    // Random button and time traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
